pic_inta_sequencer: RTL and testbench

- Synchronous interrupt-acknowledge controller for the 8259 PIC core.
- Resolves the highest-priority unmasked request from IRR/IMR against the in-service register, which it owns.
- Raises INT and sequences the two-pulse CPU INTA handshake, emitting ack1/ack2 strobes, the IRR clear and the interrupt vector.
- Applies EOI commands: AEOI, non-specific, specific and rotate-on-EOI.

---
 rtl/pic_inta_sequencer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_pic_inta_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_inta_sequencer.sv
// Purpose : 8259 interrupt-acknowledge sequencer; priority resolve, ISR ownership, INTA handshake, EOI.
// Latency : request -> int_out 1 cycle; INTA fall -> ack1 1 cycle; INTA rise in VEC -> ack2 1 cycle.
// Backpress: none; the CPU paces the handshake through inta_n, with an abort if the 2nd pulse never comes.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   irr, imr            pending requests / mask (1 = masked)
//   inta_n              CPU acknowledge, active-low, already synchronised
//   aeoi                automatic-EOI mode
//   eoi_cmd             one-cycle EOI strobe, qualified by eoi_specific / eoi_level / rotate_on_eoi
//   vector_base         ICW2 T7..T3
//   int_out             interrupt request to the CPU
//   ack1, ack2          one-cycle strobes for the first / second INTA
//   clr_irr             one-hot pulse clearing the serviced IRR bit
//   isr                 in-service register
//   vector, vector_oe   {vector_base, level} and its drive enable
//   last_serviced_idx   level of the most recent ISR clear
//
// Optional build macro PIC_SPECIAL_MASK_EN adds input smm (special mask mode):
// in-service levels that are also masked in IMR stop blocking lower levels.
module pic_inta_sequencer #(
  parameter int unsigned INTA_TIMEOUT   = 255,
  parameter int unsigned SPURIOUS_LEVEL = 7
) (
  input  logic       clk,
  input  logic       rst,
`ifdef PIC_SPECIAL_MASK_EN
  input  logic       smm,
`endif
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic       inta_n,
  input  logic       aeoi,
  input  logic       eoi_cmd,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       rotate_on_eoi,
  input  logic [4:0] vector_base,
  output logic       int_out,
  output logic       ack1,
  output logic       ack2,
  output logic [7:0] clr_irr,
  output logic [7:0] isr,
  output logic [7:0] vector,
  output logic       vector_oe,
  output logic [2:0] last_serviced_idx
);

  localparam int unsigned   TW       = (INTA_TIMEOUT > 1) ? $clog2(INTA_TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST    = TW'(INTA_TIMEOUT - 1);
  localparam logic [2:0]    SPUR_LVL = 3'(SPURIOUS_LEVEL);

  typedef enum logic [1:0] {IDLE, PEND, WAIT1, VEC} state_t;

  state_t        state;
  logic          prev;        // inta_n one cycle ago
  logic [2:0]    lowest;      // current lowest-priority level
  logic [2:0]    lvl;         // level latched at the first INTA
  logic          spur;        // current handshake is spurious
  logic          cnt_on;      // first pulse has ended, timeout running
  logic [TW-1:0] tcnt;
  logic          vec_oe_q;

  function automatic logic [7:0] bit_of(input logic [2:0] l);
    return 8'h01 << l;
  endfunction

  // ---------------------------------------------------------------
  // INTA edges
  // ---------------------------------------------------------------
  logic fall, rise;
  assign fall = prev & ~inta_n;
  assign rise = ~prev & inta_n;

  // ---------------------------------------------------------------
  // Rotated priority scan: scan_lvl[0] is the highest-priority level
  // ---------------------------------------------------------------
  logic [7:0] req;
  logic [7:0] nest;           // ISR bits that take part in nesting
  logic [2:0] scan_lvl [8];

  assign req = irr & ~imr;

`ifdef PIC_SPECIAL_MASK_EN
  assign nest = isr & ~(smm ? imr : 8'h00);
`else
  assign nest = isr;
`endif

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      scan_lvl[i] = lowest + 3'(i + 1);
    end
  end

  logic       cand_vld, nest_vld, top_vld;
  logic [2:0] cand, cand_rank, nest_rank, top_lvl;
  logic       qual;

  always_comb begin
    cand_vld  = 1'b0;
    cand      = 3'd0;
    cand_rank = 3'd0;
    nest_vld  = 1'b0;
    nest_rank = 3'd0;
    top_vld   = 1'b0;
    top_lvl   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!cand_vld && req[scan_lvl[i]]) begin
        cand_vld  = 1'b1;
        cand      = scan_lvl[i];
        cand_rank = 3'(i);
      end
      if (!nest_vld && nest[scan_lvl[i]]) begin
        nest_vld  = 1'b1;
        nest_rank = 3'(i);
      end
      // Non-specific EOI always targets the real ISR, masked or not.
      if (!top_vld && isr[scan_lvl[i]]) begin
        top_vld = 1'b1;
        top_lvl = scan_lvl[i];
      end
    end
  end

  // Strictly higher than every nesting ISR bit.
  assign qual = cand_vld && (!nest_vld || (cand_rank < nest_rank));

  // ---------------------------------------------------------------
  // ISR set/clear sources
  // ---------------------------------------------------------------
  logic       eoi_hit;
  logic [2:0] eoi_lvl;
  logic [7:0] eoi_clr;

  always_comb begin
    eoi_hit = 1'b0;
    eoi_lvl = 3'd0;
    if (eoi_cmd) begin
      if (eoi_specific) begin
        eoi_hit = 1'b1;
        eoi_lvl = eoi_level;
      end else if (top_vld) begin
        eoi_hit = 1'b1;
        eoi_lvl = top_lvl;
      end
    end
    eoi_clr = eoi_hit ? bit_of(eoi_lvl) : 8'h00;
  end

  logic [7:0] fsm_set, fsm_clr;
  logic       aeoi_done;

  always_comb begin
    fsm_set   = 8'h00;
    fsm_clr   = 8'h00;
    aeoi_done = 1'b0;
    case (state)
      PEND: begin
        if (fall && qual) fsm_set = bit_of(cand);
      end
      WAIT1: begin
        // Abandoned handshake releases the level it had taken.
        if (cnt_on && !fall && (tcnt == TLAST) && !spur) fsm_clr = bit_of(lvl);
      end
      VEC: begin
        if (rise && aeoi && !spur) begin
          fsm_clr   = bit_of(lvl);
          aeoi_done = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------
  // State machine and registered outputs
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      prev              <= 1'b1;
      lowest            <= 3'd7;
      lvl               <= 3'd0;
      spur              <= 1'b0;
      cnt_on            <= 1'b0;
      tcnt              <= '0;
      vec_oe_q          <= 1'b0;
      int_out           <= 1'b0;
      ack1              <= 1'b0;
      ack2              <= 1'b0;
      clr_irr           <= 8'h00;
      isr               <= 8'h00;
      vector            <= 8'h00;
      last_serviced_idx <= 3'd0;
    end else begin
      prev    <= inta_n;
      ack1    <= 1'b0;
      ack2    <= 1'b0;
      clr_irr <= 8'h00;

      // A set from ack1 overrides any clear of the same bit.
      isr <= (isr & ~eoi_clr & ~fsm_clr) | fsm_set;

      if (aeoi_done) begin
        last_serviced_idx <= lvl;
        if (rotate_on_eoi) lowest <= lvl;
      end
      // An explicit EOI command in the same cycle takes precedence for
      // the pointer and the last-serviced report.
      if (eoi_hit) begin
        last_serviced_idx <= eoi_lvl;
        if (rotate_on_eoi) lowest <= eoi_lvl;
      end

      case (state)
        IDLE: begin
          if (qual) begin
            state   <= PEND;
            int_out <= 1'b1;
          end
        end

        PEND: begin
          if (fall) begin
            int_out <= 1'b0;
            ack1    <= 1'b1;
            cnt_on  <= 1'b0;
            tcnt    <= '0;
            state   <= WAIT1;
            if (qual) begin
              lvl     <= cand;
              spur    <= 1'b0;
              clr_irr <= fsm_set;
            end else begin
              lvl  <= SPUR_LVL;
              spur <= 1'b1;
            end
          end else if (!qual) begin
            int_out <= 1'b0;
            state   <= IDLE;
          end
        end

        WAIT1: begin
          if (!cnt_on) begin
            if (rise) begin
              cnt_on <= 1'b1;
              tcnt   <= '0;
            end
          end else if (fall) begin
            state    <= VEC;
            vec_oe_q <= 1'b1;
            vector   <= {vector_base, lvl};
          end else if (tcnt == TLAST) begin
            state  <= IDLE;
            cnt_on <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        VEC: begin
          if (rise) begin
            ack2     <= 1'b1;
            vec_oe_q <= 1'b0;
            vector   <= 8'h00;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // The vector bus must release in the very cycle reset is asserted.
  assign vector_oe = vec_oe_q & ~rst;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
module tb_pic_inta_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] irr, imr;
  logic       inta_n, aeoi, eoi_cmd, eoi_specific, rotate_on_eoi;
  logic [2:0] eoi_level;
  logic [4:0] vector_base;
  logic       int_out, ack1, ack2, vector_oe;
  logic [7:0] clr_irr, isr, vector;
  logic [2:0] last_serviced_idx;
`ifdef PIC_SPECIAL_MASK_EN
  logic       smm;
`endif

  pic_inta_sequencer #(.INTA_TIMEOUT(4), .SPURIOUS_LEVEL(7)) dut (
    .clk               (clk),
    .rst               (rst),
`ifdef PIC_SPECIAL_MASK_EN
    .smm               (smm),
`endif
    .irr               (irr),
    .imr               (imr),
    .inta_n            (inta_n),
    .aeoi              (aeoi),
    .eoi_cmd           (eoi_cmd),
    .eoi_specific      (eoi_specific),
    .eoi_level         (eoi_level),
    .rotate_on_eoi     (rotate_on_eoi),
    .vector_base       (vector_base),
    .int_out           (int_out),
    .ack1              (ack1),
    .ack2              (ack2),
    .clr_irr           (clr_irr),
    .isr               (isr),
    .vector            (vector),
    .vector_oe         (vector_oe),
    .last_serviced_idx (last_serviced_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       io;
    logic       a1;
    logic       a2;
    logic [7:0] clr;
    logic [7:0] isr;
    logic       oe;
    logic [7:0] vec;
    logic [2:0] last;
  } out_t;

  typedef struct {
    logic       rst;
    logic [7:0] irr;
    logic [7:0] imr;
    logic       inta_n;
    logic       aeoi;
    logic       rot;
    logic       eoi;
    logic       spec;
    logic [2:0] elvl;
    out_t       exp;
  } vec_t;

  vec_t tbl[$];
  out_t exp_q[$];
  int   nvec = 0;
  int   nmis = 0;

  // Full row: eo = 0 none, 1 non-specific EOI, 2 specific EOI.
  function automatic void cx(int r, int ir, int im, int ia, int ae, int ro, int eo, int el,
                             int io, int a1, int a2, int clr, int is, int oe, int vc, int ls);
    vec_t v;
    v.rst      = (r != 0);
    v.irr      = 8'(ir);
    v.imr      = 8'(im);
    v.inta_n   = (ia != 0);
    v.aeoi     = (ae != 0);
    v.rot      = (ro != 0);
    v.eoi      = (eo != 0);
    v.spec     = (eo == 2);
    v.elvl     = 3'(el);
    v.exp.io   = (io != 0);
    v.exp.a1   = (a1 != 0);
    v.exp.a2   = (a2 != 0);
    v.exp.clr  = 8'(clr);
    v.exp.isr  = 8'(is);
    v.exp.oe   = (oe != 0);
    v.exp.vec  = 8'(vc);
    v.exp.last = 3'(ls);
    tbl.push_back(v);
  endfunction

  // Plain row: only irr and inta_n driven.
  function automatic void c(int ir, int ia, int io, int a1, int a2, int clr, int is,
                            int oe, int vc, int ls);
    cx(0, ir, 0, ia, 0, 0, 0, 0, io, a1, a2, clr, is, oe, vc, ls);
  endfunction

  initial begin
    out_t e, got;

    rst = 1'b1; irr = '0; imr = '0; inta_n = 1'b1; aeoi = 1'b0; eoi_cmd = 1'b0;
    eoi_specific = 1'b0; eoi_level = '0; rotate_on_eoi = 1'b0; vector_base = 5'h10;
`ifdef PIC_SPECIAL_MASK_EN
    smm = 1'b0;
`endif

    // reset
    cx(1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    cx(1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    // IR3 full handshake, no AEOI, then non-specific EOI
    c('h08, 1,  1, 0, 0, 0,     0,     0, 0,     0);
    c('h08, 1,  1, 0, 0, 0,     0,     0, 0,     0);
    c('h08, 0,  0, 1, 0, 'h08,  'h08,  0, 0,     0);
    c(0,    0,  0, 0, 0, 0,     'h08,  0, 0,     0);
    c(0,    1,  0, 0, 0, 0,     'h08,  0, 0,     0);
    c(0,    1,  0, 0, 0, 0,     'h08,  0, 0,     0);
    c(0,    0,  0, 0, 0, 0,     'h08,  1, 'h83,  0);
    c(0,    0,  0, 0, 0, 0,     'h08,  1, 'h83,  0);
    c(0,    1,  0, 0, 1, 0,     'h08,  0, 0,     0);
    c(0,    1,  0, 0, 0, 0,     'h08,  0, 0,     0);
    cx(0, 0, 0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 3);
    c(0,    1,  0, 0, 0, 0,     0,     0, 0,     3);
    // IR2 in service blocks IR5, IR1 nests on top
    c('h04, 1,  1, 0, 0, 0,     0,     0, 0,     3);
    c('h04, 0,  0, 1, 0, 'h04,  'h04,  0, 0,     3);
    c(0,    1,  0, 0, 0, 0,     'h04,  0, 0,     3);
    c(0,    0,  0, 0, 0, 0,     'h04,  1, 'h82,  3);
    c(0,    1,  0, 0, 1, 0,     'h04,  0, 0,     3);
    c('h20, 1,  0, 0, 0, 0,     'h04,  0, 0,     3);
    c('h20, 1,  0, 0, 0, 0,     'h04,  0, 0,     3);
    c('h02, 1,  1, 0, 0, 0,     'h04,  0, 0,     3);
    c('h02, 0,  0, 1, 0, 'h02,  'h06,  0, 0,     3);
    c(0,    1,  0, 0, 0, 0,     'h06,  0, 0,     3);
    c(0,    0,  0, 0, 0, 0,     'h06,  1, 'h81,  3);
    c(0,    1,  0, 0, 1, 0,     'h06,  0, 0,     3);
    cx(0, 0, 0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 'h04, 0, 0, 1);
    cx(0, 0, 0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0,    0, 0, 2);
    // AEOI + rotate on IR0, then IR1 wins over IR0
    cx(0, 'h01, 0, 1, 1, 1, 0, 0,  1, 0, 0, 0,    0,    0, 0,    2);
    cx(0, 'h01, 0, 0, 1, 1, 0, 0,  0, 1, 0, 'h01, 'h01, 0, 0,    2);
    cx(0, 0,    0, 1, 1, 1, 0, 0,  0, 0, 0, 0,    'h01, 0, 0,    2);
    cx(0, 0,    0, 0, 1, 1, 0, 0,  0, 0, 0, 0,    'h01, 1, 'h80, 2);
    cx(0, 0,    0, 1, 1, 1, 0, 0,  0, 0, 1, 0,    0,    0, 0,    0);
    c('h03, 1,  1, 0, 0, 0,     0,     0, 0,     0);
    c('h03, 0,  0, 1, 0, 'h02,  'h02,  0, 0,     0);
    c('h01, 1,  0, 0, 0, 0,     'h02,  0, 0,     0);
    c('h01, 0,  0, 0, 0, 0,     'h02,  1, 'h81,  0);
    c('h01, 1,  0, 0, 1, 0,     'h02,  0, 0,     0);
    c('h01, 1,  0, 0, 0, 0,     'h02,  0, 0,     0);
    cx(0, 'h01, 0, 1, 0, 0, 2, 1,  0, 0, 0, 0, 0, 0, 0, 1);
    // reset in the middle of the vector phase
    c('h01, 1,  1, 0, 0, 0,     0,     0, 0,     1);
    c('h01, 0,  0, 1, 0, 'h01,  'h01,  0, 0,     1);
    c(0,    1,  0, 0, 0, 0,     'h01,  0, 0,     1);
    c(0,    0,  0, 0, 0, 0,     'h01,  1, 'h80,  1);
    cx(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    c(0,    0,  0, 0, 0, 0,     0,     0, 0,     0);
    c(0,    1,  0, 0, 0, 0,     0,     0, 0,     0);
    // masked request, spurious first INTA, request withdrawn in PEND
    cx(0, 'h10, 'h10, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    c('h10, 1,  1, 0, 0, 0,     0,     0, 0,     0);
    c(0,    0,  0, 1, 0, 0,     0,     0, 0,     0);
    c(0,    1,  0, 0, 0, 0,     0,     0, 0,     0);
    c(0,    0,  0, 0, 0, 0,     0,     1, 'h87,  0);
    c(0,    1,  0, 0, 1, 0,     0,     0, 0,     0);
    c('h20, 1,  1, 0, 0, 0,     0,     0, 0,     0);
    c(0,    1,  0, 0, 0, 0,     0,     0, 0,     0);
    c(0,    1,  0, 0, 0, 0,     0,     0, 0,     0);
    // second INTA never arrives: abort after 4 cycles
    c('h20, 1,  1, 0, 0, 0,     0,     0, 0,     0);
    c('h20, 0,  0, 1, 0, 'h20,  'h20,  0, 0,     0);
    c(0,    0,  0, 0, 0, 0,     'h20,  0, 0,     0);
    c(0,    1,  0, 0, 0, 0,     'h20,  0, 0,     0);
    c(0,    1,  0, 0, 0, 0,     'h20,  0, 0,     0);
    c(0,    1,  0, 0, 0, 0,     'h20,  0, 0,     0);
    c(0,    1,  0, 0, 0, 0,     'h20,  0, 0,     0);
    c(0,    1,  0, 0, 0, 0,     0,     0, 0,     0);
    c(0,    0,  0, 0, 0, 0,     0,     0, 0,     0);
    c(0,    1,  0, 0, 0, 0,     0,     0, 0,     0);
    // EOI vs ack1 on same bit (set wins), 2nd INTA on last allowed cycle,
    // EOI vs ack1 on different bits, then AEOI
    c('h04, 1,  1, 0, 0, 0,     0,     0, 0,     0);
    cx(0, 'h04, 0, 0, 0, 0, 2, 2,  0, 1, 0, 'h04, 'h04, 0, 0, 2);
    c(0,    0,  0, 0, 0, 0,     'h04,  0, 0,     2);
    c(0,    1,  0, 0, 0, 0,     'h04,  0, 0,     2);
    c(0,    1,  0, 0, 0, 0,     'h04,  0, 0,     2);
    c(0,    1,  0, 0, 0, 0,     'h04,  0, 0,     2);
    c(0,    1,  0, 0, 0, 0,     'h04,  0, 0,     2);
    c(0,    0,  0, 0, 0, 0,     'h04,  1, 'h82,  2);
    c(0,    1,  0, 0, 1, 0,     'h04,  0, 0,     2);
    c('h02, 1,  1, 0, 0, 0,     'h04,  0, 0,     2);
    cx(0, 'h02, 0, 0, 0, 0, 2, 2,  0, 1, 0, 'h02, 'h02, 0, 0, 2);
    c(0,    1,  0, 0, 0, 0,     'h02,  0, 0,     2);
    c(0,    0,  0, 0, 0, 0,     'h02,  1, 'h81,  2);
    cx(0, 0, 0, 1, 1, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0, 1);
    c(0,    1,  0, 0, 0, 0,     0,     0, 0,     1);

    for (int k = 0; k < tbl.size(); k++) begin
      rst           = tbl[k].rst;
      irr           = tbl[k].irr;
      imr           = tbl[k].imr;
      inta_n        = tbl[k].inta_n;
      aeoi          = tbl[k].aeoi;
      rotate_on_eoi = tbl[k].rot;
      eoi_cmd       = tbl[k].eoi;
      eoi_specific  = tbl[k].spec;
      eoi_level     = tbl[k].elvl;
      exp_q.push_back(tbl[k].exp);

      if (tbl[k].rst) begin
        #1;
        nvec++;
        if (vector_oe !== 1'b0) begin
          nmis++;
          $display("FAIL rst_oe row %0d: vector_oe=%0b, required 0", k, vector_oe);
        end
      end

      @(posedge clk);
      #1;
      e   = exp_q.pop_front();
      got = '{int_out, ack1, ack2, clr_irr, isr, vector_oe, vector, last_serviced_idx};
      // The vector bus content only matters while it is driven.
      if (!e.oe) begin
        got.vec = 8'h00;
        e.vec   = 8'h00;
      end
      nvec++;
      if (got !== e) begin
        nmis++;
        $display("FAIL row %0d: got io=%0b a1=%0b a2=%0b clr=%02h isr=%02h oe=%0b vec=%02h last=%0d, need io=%0b a1=%0b a2=%0b clr=%02h isr=%02h oe=%0b vec=%02h last=%0d",
                 k, got.io, got.a1, got.a2, got.clr, got.isr, got.oe, got.vec, got.last,
                 e.io, e.a1, e.a2, e.clr, e.isr, e.oe, e.vec, e.last);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
